// File: rtl/addition_pkg.sv
// Shared definitions for the single-precision adder pipeline stages.
package addition_pkg;

  localparam int unsigned MENT_WIDTH_DEFAULT = 23;
  localparam int unsigned EXPO_WIDTH_DEFAULT = 8;
  localparam logic [EXPO_WIDTH_DEFAULT-1:0] EXPO_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/addition_normalizer.sv
// Post-addition normalization: carry right-shift or iterative left-shift to
// restore the hidden bit, with zero/overflow/underflow status.
module addition_normalizer
  import addition_pkg::*;
#(
  parameter int unsigned MENT_WIDTH = MENT_WIDTH_DEFAULT,
  parameter int unsigned EXPO_WIDTH = EXPO_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MENT_WIDTH+1:0] mant_in,
  input  logic [EXPO_WIDTH-1:0] expo_in,
  input  logic                  sign_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MENT_WIDTH-1:0] mant_out,
  output logic [EXPO_WIDTH-1:0] expo_out,
  output logic                  sign_out,
  output logic                  zero_flag,
  output logic                  overflow_flag,
  output logic                  underflow_flag
);

  localparam int unsigned MW = MENT_WIDTH;
  localparam int unsigned EW = EXPO_WIDTH;
  // Exponent kept one bit wider so increment/decrement never wraps.
  localparam logic [EW:0] EXPO_ONES = {1'b0, {EW{1'b1}}};
  localparam logic [EW:0] EXPO_ONE  = (EW+1)'(1);

  state_e state_q, state_d;

  logic [MW+1:0] mant_q, mant_d;
  logic [EW:0]   expo_q, expo_d;
  logic          sign_q, sign_d;
  logic          zero_q, zero_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic [MW+1:0] mant_shl;
  logic [EW:0]   expo_inc;
  logic [EW:0]   expo_dec;
  logic          chk_done;

  assign mant_shl = {mant_q[MW:0], 1'b0};
  assign expo_inc = expo_q + EXPO_ONE;
  assign expo_dec = expo_q - EXPO_ONE;

  // CHECK resolves in one step for zero, carry, normalized and floor cases.
  assign chk_done = (mant_q == '0) || mant_q[MW+1] || mant_q[MW] ||
                    (expo_q <= EXPO_ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = CHECK;
      CHECK:   state_d = chk_done ? DONE : SHIFT;
      SHIFT:   if (mant_shl[MW] || (expo_dec == EXPO_ONE)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Working register updates; DONE leaves everything untouched.
  always_comb begin
    mant_d = mant_q;
    expo_d = expo_q;
    sign_d = sign_q;
    zero_d = zero_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mant_d = mant_in;
          expo_d = {1'b0, expo_in};
          sign_d = sign_in;
          zero_d = 1'b0;
          ovf_d  = 1'b0;
          unf_d  = 1'b0;
        end
      end
      CHECK: begin
        if (mant_q == '0) begin
          expo_d = '0;
          zero_d = 1'b1;
        end else if (mant_q[MW+1]) begin
          mant_d = mant_q >> 1;
          expo_d = expo_inc;
          if (expo_inc >= EXPO_ONES) begin
            mant_d = '0;
            expo_d = EXPO_ONES;
            ovf_d  = 1'b1;
          end
        end else if (!mant_q[MW] && (expo_q <= EXPO_ONE)) begin
          expo_d = '0;
          unf_d  = 1'b1;
        end
      end
      SHIFT: begin
        mant_d = mant_shl;
        expo_d = expo_dec;
        if (!mant_shl[MW] && (expo_dec == EXPO_ONE)) begin
          expo_d = '0;
          unf_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mant_q <= '0;
      expo_q <= '0;
      sign_q <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      mant_q <= mant_d;
      expo_q <= expo_d;
      sign_q <= sign_d;
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign mant_out       = mant_q[MW-1:0];
  assign expo_out       = expo_q[EW-1:0];
  assign sign_out       = sign_q;
  assign zero_flag      = zero_q;
  assign overflow_flag  = ovf_q;
  assign underflow_flag = unf_q;

endmodule

// File: tb/tb_addition_normalizer.sv
// Directed self-checking bench for addition_normalizer.
module tb_addition_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] mant_in;
  logic [7:0]  expo_in;
  logic        sign_in;
  logic        out_valid;
  logic        out_ready;
  logic [22:0] mant_out;
  logic [7:0]  expo_out;
  logic        sign_out;
  logic        zero_flag;
  logic        overflow_flag;
  logic        underflow_flag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  addition_normalizer #(.MENT_WIDTH(23), .EXPO_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .mant_in(mant_in), .expo_in(expo_in), .sign_in(sign_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .mant_out(mant_out), .expo_out(expo_out), .sign_out(sign_out),
    .zero_flag(zero_flag), .overflow_flag(overflow_flag),
    .underflow_flag(underflow_flag)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] flags();
    return {zero_flag, overflow_flag, underflow_flag};
  endfunction

  // Accept one operand on the next rising edge (called at a falling edge).
  task automatic accept(input logic [24:0] m, input logic [7:0] e, input logic s);
    in_valid = 1'b1;
    mant_in  = m;
    expo_in  = e;
    sign_in  = s;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count rising edges after accept until out_valid (bounded).
  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " idle_valid"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [24:0] m, input logic [7:0] e,
                        input logic s, input logic [22:0] x_mant, input logic [7:0] x_expo,
                        input logic [2:0] x_flags, input int x_lat);
    int lat;
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    accept(m, e, s);
    wait_done(lat);
    chk({tag, " latency"}, 32'(lat), 32'(x_lat));
    chk({tag, " mant"}, 32'(mant_out), 32'(x_mant));
    chk({tag, " expo"}, 32'(expo_out), 32'(x_expo));
    chk({tag, " sign"}, 32'(sign_out), 32'(s));
    chk({tag, " flags"}, 32'(flags()), 32'(x_flags));
    release_out(tag);
  endtask

  initial begin
    logic [22:0] held_mant;
    logic [7:0]  held_expo;
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mant_in   = '0;
    expo_in   = '0;
    sign_in   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst mant", 32'(mant_out), 32'd0);
    chk("rst expo", 32'(expo_out), 32'd0);
    chk("rst sign_flags", 32'({sign_out, flags()}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("carry",    25'h1800000, 8'd127, 1'b0, 23'h400000, 8'd128, 3'b000, 2);
    run_op("norm",     25'h0C00000, 8'd100, 1'b0, 23'h400000, 8'd100, 3'b000, 2);
    run_op("shift3",   25'h0100000, 8'd100, 1'b1, 23'h000000, 8'd97,  3'b000, 5);
    run_op("zero",     25'h0000000, 8'd50,  1'b1, 23'h000000, 8'd0,   3'b100, 2);
    run_op("overflow", 25'h1000000, 8'd254, 1'b0, 23'h000000, 8'd255, 3'b010, 2);
    run_op("underflow",25'h0000001, 8'd3,   1'b0, 23'h000004, 8'd0,   3'b001, 4);
    run_op("floor",    25'h0400000, 8'd1,   1'b0, 23'h400000, 8'd0,   3'b001, 2);
    run_op("carry_odd",25'h1000003, 8'd10,  1'b1, 23'h000001, 8'd11,  3'b000, 2);

    // Backpressure: outputs frozen and new operands ignored while out_ready=0.
    accept(25'h0080000, 8'd20, 1'b1);
    wait_done(lat);
    chk("bp latency", 32'(lat), 32'd6);
    held_mant = mant_out;
    held_expo = expo_out;
    chk("bp mant", 32'(held_mant), 32'd0);
    chk("bp expo", 32'(held_expo), 32'd16);
    in_valid = 1'b1;
    mant_in  = 25'h1FFFFFF;
    expo_in  = 8'd200;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp valid", 32'(out_valid), 32'd1);
      chk("bp ready", 32'(in_ready), 32'd0);
      chk("bp hold", 32'({held_expo, held_mant}), 32'({expo_out, mant_out}));
    end
    in_valid = 1'b0;
    release_out("bp");

    // Reset in SHIFT: immediate return to IDLE, then a clean operation.
    accept(25'h0000001, 8'd100, 1'b1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid mant", 32'(mant_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("after_rst", 25'h0200000, 8'd40, 1'b0, 23'h000000, 8'd38, 3'b000, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addition_normalizer.md
# addition_normalizer

Post-addition normalization stage of the single-precision FP adder. It takes the raw mantissa sum from mantissa addition, together with the pre-normalization exponent and sign. It renormalizes the result: a one-bit right shift on carry-out, or an iterative left shift to restore the hidden bit. It then emits the packed sign/exponent/fraction with status flags. It is the counterpart of the right-shift alignment stage, and sits between mantissa addition and result packing, behind a valid/ready handshake.

## Interface
Parameters:
- MENT_WIDTH, 23, fraction width (hidden bit excluded)
- EXPO_WIDTH, 8, biased exponent width

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand present
- in_ready  output  1  block can accept (high only in IDLE)
- mant_in  input  MENT_WIDTH+2  raw sum; bit MENT_WIDTH+1 = carry, bit MENT_WIDTH = hidden
- expo_in  input  EXPO_WIDTH  exponent of the larger operand
- sign_in  input  1  result sign
- out_valid  output  1  result present (high only in DONE)
- out_ready  input  1  downstream accepts result
- mant_out  output  MENT_WIDTH  normalized fraction
- expo_out  output  EXPO_WIDTH  normalized biased exponent
- sign_out  output  1  sign_in passed through
- zero_flag, overflow_flag, underflow_flag  output  1 each  result status

## Operation
- FSM states: IDLE, CHECK, SHIFT, DONE.
- **IDLE**: in_ready=1. When in_valid is high, the block captures mant_in/expo_in/sign_in into working registers and goes to CHECK.
- **CHECK** evaluates, in priority order:
  - **zero**: mant=0 → expo=0, zero_flag=1, go to DONE.
  - **carry**: mant >>=1 (LSB truncated, no rounding), expo+1. If the new expo is all-ones, then mant=0 and overflow_flag=1. Go to DONE.
  - **normalized**: hidden bit set → DONE.
  - **floor**: expo ≤ 1 and hidden bit clear → expo=0, underflow_flag=1, go to DONE.
  - otherwise → SHIFT.
- **SHIFT**: each cycle, mant <<=1 and expo−1. Go to DONE in the same cycle the shifted value has its hidden bit set, or the new expo equals 1.
  - If expo reaches 1 with the hidden bit still clear, the result is denormal: expo_out=0, underflow_flag=1.
- **DONE**: out_valid=1, and outputs are held stable. Go to IDLE on out_ready.
- Shift count n = min(leading zeros of bits MENT_WIDTH:0, expo_in−1).
- Exponent arithmetic is performed in EXPO_WIDTH+1 bits so that wrap-around cannot occur.
- sign_out always equals the captured sign_in, including for zero results.

## Timing
- Reset (asynchronous):
  - state=IDLE
  - all working/output registers 0, so mant_out/expo_out/sign_out/flags = 0
  - out_valid=0, in_ready=1 (decoded from state)
- Latency from the accept edge to out_valid is 2+n cycles:
  - n=0 for the zero, carry, normalized and floor cases, giving 2 cycles.
- Throughput: one operation per 3+n cycles minimum. in_ready is low from CHECK through DONE.
- Backpressure: out_valid is held indefinitely while out_ready=0, with outputs constant. in_valid is ignored outside IDLE.
- rst asserted mid-operation discards the operation and returns to IDLE on the same edge.
- The DONE→IDLE transition and a new accept never share a cycle.

## Structure
- Shared package addition_pkg:
  - MENT_WIDTH/EXPO_WIDTH defaults
  - EXPO_MAX (all-ones) constant
  - state enum {IDLE, CHECK, SHIFT, DONE}
- The package is shared with the other adder stages.
- No sub-module: the one-bit shift/decrement step and the flag logic are inline. A single FSM is used, with registered outputs.

## Test plan
- Carry: mant_in=25'h1800000, expo_in=127 → mant_out=23'h400000, expo_out=128, flags 0, out_valid 2 cycles after accept.
- Already normalized: mant_in=25'h0C00000, expo_in=100 → mant_out=23'h400000, expo_out=100, latency 2.
- Three-place shift: mant_in=25'h0100000, expo_in=100 → mant_out=23'h000000, expo_out=97, latency 5.
- Zero and overflow:
  - mant_in=0, expo_in=50, sign_in=1 → expo_out=0, zero_flag=1, sign_out=1.
  - mant_in=25'h1000000, expo_in=254 → expo_out=255, mant_out=0, overflow_flag=1.
- Underflow: mant_in=25'h0000001, expo_in=3 → two shifts, mant_out=23'h000004, expo_out=0, underflow_flag=1, latency 4.
- Handshake/reset:
  - Hold out_ready=0 for 10 cycles → outputs stable, in_ready=0.
  - Assert rst during SHIFT → out_valid=0 and in_ready=1 immediately, and the next operand is processed correctly.
